v_dispatch: RTL

//  Base-processor-side issue bridge for the CARRD vector coprocessor. Buffers vector

---
 rtl/v_dispatch.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/v_dispatch.sv
// Issue bridge toward the CARRD vector coprocessor: queues instructions with their
// scalar operands, presents one at a time, and retires it on v_done or on timeout.
module v_dispatch #(
  parameter int FIFO_DEPTH   = 4,
  parameter int DONE_TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [31:0]                   in_instr,
  input  logic [31:0]                   in_rs1_val,
  input  logic [31:0]                   in_rs2_val,
  output logic [31:0]                   v_instr,
  output logic [31:0]                   xreg_out1,
  output logic [31:0]                   xreg_out2,
  input  logic                          v_done,
  output logic                          busy,
  output logic                          retire,
  output logic                          timeout_err,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy,
  output logic [1:0]                    o_dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
  localparam logic [AW:0]   LP_DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] LP_TMAX  = TW'(DONE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [95:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [95:0]   r_issue;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_nxt;
  logic          r_retire;
  logic          w_retire_nxt;
  logic          r_err;
  logic          w_err_nxt;
  logic          w_push;
  logic          w_pop;
  logic          w_is_vsetvl;

  // Handshake: an entry transfers on a rising edge where in_valid & in_ready are both
  // high; in_ready depends only on occupancy, and the offering side holds in_valid and
  // its data stable until that transfer happens.
  assign in_ready = (r_count != LP_DEPTH);
  assign w_push   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: pointers and count define which slots are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {in_rs2_val, in_rs1_val, in_instr};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_issue <= '0;
    end else if (w_pop) begin
      r_issue <= r_mem[r_rd_ptr];
    end
  end

  // Configuration ops complete inside the bridge and never wait for v_done.
  assign w_is_vsetvl = (r_issue[6:0] == 7'b1010111) && (r_issue[14:12] == 3'b111);

  always_comb begin
    w_state_nxt  = r_state;
    w_pop        = 1'b0;
    w_timer_nxt  = r_timer;
    w_retire_nxt = 1'b0;
    w_err_nxt    = r_err;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_is_vsetvl) begin
          w_retire_nxt = 1'b1;
          w_state_nxt  = S_IDLE;
        end else begin
          w_timer_nxt = '0;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (v_done) begin
          w_retire_nxt = 1'b1;
          w_state_nxt  = S_IDLE;
        end else if (r_timer == LP_TMAX) begin
          w_err_nxt    = 1'b1;
          w_retire_nxt = 1'b1;
          w_state_nxt  = S_IDLE;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_retire <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_retire <= w_retire_nxt;
      r_err    <= w_err_nxt;
    end
  end

  // The bus drops to zero in IDLE so consecutive instructions decode as distinct.
  assign v_instr     = (r_state != S_IDLE) ? r_issue[31:0]  : '0;
  assign xreg_out1   = (r_state != S_IDLE) ? r_issue[63:32] : '0;
  assign xreg_out2   = (r_state != S_IDLE) ? r_issue[95:64] : '0;
  assign retire      = r_retire;
  assign timeout_err = r_err;
  assign occupancy   = r_count;
  assign busy        = (r_count != '0) || (r_state != S_IDLE);
  assign o_dbg_state = r_state;

endmodule
